// File: rtl/clk_monitor.sv
// clk_monitor: measures an asynchronous clock or strobe in the clk domain.
// Free-running statistics (edge count, last period, last high time), an
// armed N-period window measurement and a stall timeout while a window
// measurement is in progress.
module clk_monitor #(
   parameter int COUNT_BITS  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mon_in,
   input  logic                  clear,
   input  logic                  start,
   input  logic [COUNT_BITS-1:0] target,
   input  logic [COUNT_BITS-1:0] timeout,
   output logic [COUNT_BITS-1:0] edge_count,
   output logic [COUNT_BITS-1:0] period,
   output logic [COUNT_BITS-1:0] high_time,
   output logic [COUNT_BITS-1:0] elapsed,
   output logic                  busy,
   output logic                  done,
   output logic                  stalled
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [COUNT_BITS-1:0] ONE = {{(COUNT_BITS-1){1'b0}}, 1'b1};

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
      return (&v) ? v : (v + ONE);
   endfunction

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;
   logic                   sync_s;
   logic                   rise_s;
   logic                   fall_s;
   logic [COUNT_BITS-1:0]  since_rise_r;
   logic                   seen_rise_r;
   logic [COUNT_BITS-1:0]  win_r;
   logic [COUNT_BITS-1:0]  idle_r;
   logic [COUNT_BITS-1:0]  target_r;
   logic [COUNT_BITS-1:0]  timeout_r;
   state_t                 state_r;
   state_t                 state_nx_s;
   logic                   arm_s;
   logic                   open_s;
   logic                   stall_s;
   logic                   busy_st_s;
   logic                   timeout_hit_s;

   assign sync_s = sync_r[SYNC_STAGES-1];
   assign rise_s = sync_s & ~prev_r;
   assign fall_s = ~sync_s & prev_r;

   // Synchronizer chain plus one-cycle-delayed copy for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_r <= '0;
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], mon_in};
         prev_r <= sync_s;
      end
   end

   // Busy decode of the current state.
   always_comb begin
      if ((state_r == ST_ARMED) || (state_r == ST_MEASURE)) begin
         busy_st_s = 1'b1;
      end else begin
         busy_st_s = 1'b0;
      end
   end

   // Stall detection: no rising edge for timeout cycles while busy.
   always_comb begin
      if (busy_st_s && (timeout_r != '0) && !rise_s && (idle_r == (timeout_r - ONE))) begin
         timeout_hit_s = 1'b1;
      end else begin
         timeout_hit_s = 1'b0;
      end
   end

   // Window FSM next-state and control strobes; clear beats timeout beats edges beats start.
   always_comb begin
      state_nx_s = state_r;
      arm_s      = 1'b0;
      open_s     = 1'b0;
      stall_s    = 1'b0;
      if (clear) begin
         state_nx_s = ST_IDLE;
      end else if (timeout_hit_s) begin
         state_nx_s = ST_IDLE;
         stall_s    = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start && (target != '0)) begin
                  state_nx_s = ST_ARMED;
                  arm_s      = 1'b1;
               end else begin
                  state_nx_s = state_r;
               end
            end
            ST_ARMED: begin
               if (rise_s) begin
                  state_nx_s = ST_MEASURE;
                  open_s     = 1'b1;
               end else begin
                  state_nx_s = ST_ARMED;
               end
            end
            ST_MEASURE: begin
               if (rise_s && ((win_r + ONE) == target_r)) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_MEASURE;
               end
            end
            default: begin
               state_nx_s = ST_IDLE;
            end
         endcase
      end
   end

   // FSM state register with registered busy/done flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy    <= (state_nx_s == ST_ARMED) || (state_nx_s == ST_MEASURE);
         done    <= (state_nx_s == ST_DONE);
      end
   end

   // Free-running edge statistics; clear drops any edge of its own cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         since_rise_r <= '0;
         seen_rise_r  <= 1'b0;
         edge_count   <= '0;
         period       <= '0;
         high_time    <= '0;
      end else if (clear) begin
         since_rise_r <= '0;
         seen_rise_r  <= 1'b0;
         edge_count   <= '0;
         period       <= '0;
         high_time    <= '0;
      end else begin
         since_rise_r <= rise_s ? '0 : sat_inc(since_rise_r);
         if (rise_s) begin
            edge_count  <= sat_inc(edge_count);
            seen_rise_r <= 1'b1;
            if (seen_rise_r) begin
               period <= sat_inc(since_rise_r);
            end
         end
         if (fall_s && seen_rise_r) begin
            high_time <= sat_inc(since_rise_r);
         end
      end
   end

   // Window datapath: elapsed, in-window rise count, idle counter, sticky stall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         elapsed   <= '0;
         win_r     <= '0;
         idle_r    <= '0;
         target_r  <= '0;
         timeout_r <= '0;
         stalled   <= 1'b0;
      end else if (clear) begin
         elapsed <= '0;
         win_r   <= '0;
         idle_r  <= '0;
         stalled <= 1'b0;
      end else begin
         if (arm_s) begin
            elapsed   <= '0;
            win_r     <= '0;
            target_r  <= target;
            timeout_r <= timeout;
         end else if (open_s) begin
            elapsed <= '0;
            win_r   <= '0;
         end else if ((state_r == ST_MEASURE) && !stall_s) begin
            elapsed <= sat_inc(elapsed);
            if (rise_s) begin
               win_r <= win_r + ONE;
            end
         end
         if (arm_s) begin
            idle_r <= '0;
         end else if (busy_st_s) begin
            idle_r <= rise_s ? '0 : sat_inc(idle_r);
         end
         if (arm_s) begin
            stalled <= 1'b0;
         end else if (stall_s) begin
            stalled <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clk_monitor.sv
// Self-checking bench for clk_monitor: edge-index based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_clk_monitor;

   localparam int CB = 32;
   localparam int S  = 2;

   logic          clk;
   logic          reset;
   logic          mon_in;
   logic          clear;
   logic          start;
   logic [CB-1:0] target;
   logic [CB-1:0] timeout;
   logic [CB-1:0] edge_count;
   logic [CB-1:0] period;
   logic [CB-1:0] high_time;
   logic [CB-1:0] elapsed;
   logic          busy;
   logic          done;
   logic          stalled;

   int total = 0;
   int bad   = 0;

   clk_monitor #(.COUNT_BITS(CB), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .mon_in(mon_in), .clear(clear), .start(start),
      .target(target), .timeout(timeout), .edge_count(edge_count), .period(period),
      .high_time(high_time), .elapsed(elapsed), .busy(busy), .done(done), .stalled(stalled)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [CB-1:0] act, input logic [CB-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Wave generator: hi_len cycles high, lo_len cycles low, or held low.
   bit wave_en = 1'b0;
   int hi_len  = 2;
   int lo_len  = 2;
   int ph      = 0;
   initial begin
      mon_in = 1'b0;
      forever begin
         @(negedge clk);
         if (wave_en) begin
            mon_in = (ph < hi_len);
            ph = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
         end else begin
            mon_in = 1'b0;
            ph = 0;
         end
      end
   end

   // Reference model in terms of posedge indices of detected edges.
   int   n = 0;
   logic hq [0:S];
   logic r, f;
   int   m_edge, m_period, m_high, m_elapsed, m_st;
   bit   m_stalled, have_rise;
   int   last_rise_n, open_n, last_act_n, nr, tgt, tmo;

   task automatic model_zero();
      m_edge = 0; m_period = 0; m_high = 0; m_elapsed = 0;
      m_stalled = 1'b0; have_rise = 1'b0; m_st = 0;
   endtask

   initial begin
      for (int i = 0; i <= S; i++) hq[i] = 1'b0;
      model_zero();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            for (int i = 0; i <= S; i++) hq[i] = 1'b0;
            model_zero();
         end else begin
            n++;
            // A sample becomes an edge S posedges after it was taken.
            r = hq[S-1] & ~hq[S];
            f = ~hq[S-1] & hq[S];
            for (int i = S; i >= 1; i--) hq[i] = hq[i-1];
            hq[0] = mon_in;
            if (clear) begin
               model_zero();
            end else begin
               if (f && have_rise) m_high = n - last_rise_n;
               if (r) begin
                  m_edge++;
                  if (have_rise) m_period = n - last_rise_n;
                  last_rise_n = n;
                  have_rise = 1'b1;
               end
               if ((m_st == 1 || m_st == 2) && tmo != 0 && !r && (n - last_act_n) == tmo) begin
                  m_st = 0;
                  m_stalled = 1'b1;
               end else if (m_st == 1) begin
                  if (r) begin
                     m_st = 2; open_n = n; m_elapsed = 0; nr = 0; last_act_n = n;
                  end
               end else if (m_st == 2) begin
                  m_elapsed = n - open_n;
                  if (r) begin
                     nr++;
                     last_act_n = n;
                     if (nr == tgt) m_st = 3;
                  end
               end else if (start && target != '0) begin
                  m_st = 1; last_act_n = n; m_elapsed = 0; m_stalled = 1'b0;
                  tgt = int'(target); tmo = int'(timeout);
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            chk("m_edge_count", edge_count, CB'(m_edge));
            chk("m_period",     period,     CB'(m_period));
            chk("m_high_time",  high_time,  CB'(m_high));
            chk("m_elapsed",    elapsed,    CB'(m_elapsed));
            chk("m_busy",       CB'(busy),    CB'((m_st == 1 || m_st == 2) ? 1 : 0));
            chk("m_done",       CB'(done),    CB'((m_st == 3) ? 1 : 0));
            chk("m_stalled",    CB'(stalled), CB'(m_stalled));
         end
      end
   end

   task automatic cyc(input int k);
      repeat (k) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input logic [CB-1:0] t, input logic [CB-1:0] to);
      target = t; timeout = to; start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int k = 0;
      while (done !== 1'b1 && k < bound) begin
         cyc(1);
         k++;
      end
      chk("wait_done", CB'(done), CB'(1));
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_edge"},    edge_count, '0);
      chk({tag, "_period"},  period,     '0);
      chk({tag, "_high"},    high_time,  '0);
      chk({tag, "_elapsed"}, elapsed,    '0);
      chk({tag, "_busy"},    CB'(busy),    '0);
      chk({tag, "_done"},    CB'(done),    '0);
      chk({tag, "_stalled"}, CB'(stalled), '0);
   endtask

   logic prevm;
   int   k;

   initial begin
      reset = 1'b0; clear = 1'b0; start = 1'b0; target = '0; timeout = '0;
      #1;
      all_zero("rst");
      cyc(3);
      reset = 1'b1;

      // Divide-by-4 square wave statistics.
      hi_len = 2; lo_len = 2; wave_en = 1'b1;
      k = 0;
      while (edge_count < 10 && k < 100) begin cyc(1); k++; end
      chk("div4_edges",  edge_count, 32'd10);
      chk("div4_period", period,     32'd4);
      chk("div4_high",   high_time,  32'd2);

      // Divide-by-6 window of 3 periods, then re-measure.
      hi_len = 3; lo_len = 3;
      cyc(20);
      pulse_clear();
      chk("clr_edges", edge_count, 32'd0);
      cyc(2);
      pulse_start(32'd3, 32'd0);
      chk("win6_busy", CB'(busy), 32'd1);
      wait_done(100);
      chk("win6_elapsed", elapsed,   32'd18);
      chk("win6_busy0",   CB'(busy), 32'd0);
      chk("div6_period",  period,    32'd6);
      chk("div6_high",    high_time, 32'd3);
      pulse_start(32'd3, 32'd0);
      chk("rearm_done0", CB'(done), 32'd0);
      wait_done(100);
      chk("rearm_elapsed", elapsed, 32'd18);

      // Start while busy must not disturb the running window.
      hi_len = 2; lo_len = 2;
      cyc(12);
      pulse_start(32'd2, 32'd0);
      cyc(6);
      chk("busy_before_restart", CB'(busy), 32'd1);
      pulse_start(32'd7, 32'd0);
      wait_done(100);
      chk("busy_start_elapsed", elapsed, 32'd8);

      // Stopped input: stall exactly 50 cycles after arming.
      wave_en = 1'b0;
      cyc(6);
      pulse_start(32'd2, 32'd50);
      chk("stall_busy_arm", CB'(busy), 32'd1);
      chk("stall_clr_arm",  CB'(stalled), 32'd0);
      cyc(49);
      chk("stall_busy49",    CB'(busy),    32'd1);
      chk("stall_stalled49", CB'(stalled), 32'd0);
      cyc(1);
      chk("stall_stalled50", CB'(stalled), 32'd1);
      chk("stall_busy50",    CB'(busy),    32'd0);
      chk("stall_done50",    CB'(done),    32'd0);
      cyc(3);
      chk("stall_sticky", CB'(stalled), 32'd1);

      // Start with target 0 is ignored.
      pulse_start(32'd0, 32'd5);
      chk("t0_busy",    CB'(busy),    32'd0);
      chk("t0_stalled", CB'(stalled), 32'd1);
      cyc(2);
      chk("t0_busy2", CB'(busy), 32'd0);

      // Clear coinciding with a rise in mid-MEASURE.
      hi_len = 2; lo_len = 2; wave_en = 1'b1;
      cyc(10);
      pulse_start(32'd5, 32'd0);
      k = 0;
      while (elapsed < 6 && k < 50) begin cyc(1); k++; end
      chk("clr_in_measure", CB'(busy), 32'd1);
      k = 0;
      prevm = mon_in;
      cyc(1);
      while (!(mon_in === 1'b1 && prevm === 1'b0) && k < 20) begin
         prevm = mon_in;
         cyc(1);
         k++;
      end
      cyc(2);
      pulse_clear();
      all_zero("clr");
      cyc(2);
      chk("clr_edge_late", edge_count, 32'd0);

      // Asynchronous reset between clock edges in mid-MEASURE.
      pulse_start(32'd3, 32'd0);
      cyc(8);
      #2;
      reset = 1'b0;
      #1;
      all_zero("arst");
      cyc(1);
      reset = 1'b1;
      hi_len = 1; lo_len = 1;
      cyc(8);
      pulse_start(32'd1, 32'd0);
      wait_done(50);
      chk("fast_elapsed", elapsed, 32'd2);
      chk("fast_period",  period,  32'd2);
      cyc(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
